// File: rtl/y2x_pipe.sv
`default_nettype none
// y2x_pipe - 3-stage valid/ready 3x3 colour-space converter with bypass and a
// config reload that waits for the pipeline to drain.  Rev 1.0
module y2x_pipe #(
  parameter int COEF_DW = 12,
  parameter int PIX_DW  = 8,
  parameter int OFS_DW  = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_vld,
  output logic                 in_rdy,
  input  logic [PIX_DW-1:0]    in_y,
  input  logic [PIX_DW-1:0]    in_xb,
  input  logic [PIX_DW-1:0]    in_xr,
  output logic                 out_vld,
  input  logic                 out_rdy,
  output logic [PIX_DW-1:0]    pre_r,
  output logic [PIX_DW-1:0]    pre_g,
  output logic [PIX_DW-1:0]    pre_b,
  input  logic [9*COEF_DW-1:0] cfg_coef,
  input  logic [3*OFS_DW-1:0]  cfg_ofs,
  input  logic [11:0]          cfg_sign,
  input  logic [PIX_DW-1:0]    cfg_round,
  input  logic [4:0]           cfg_shift,
  input  logic                 cfg_bypass,
  input  logic                 cfg_load,
  output logic                 cfg_ack
);

  localparam int PROD_W = COEF_DW + PIX_DW;
  localparam int SUM_W  = PROD_W + 3;
  localparam int RES_W  = SUM_W + 1;

  typedef enum logic [0:0] {CFG_IDLE = 1'b0, CFG_PEND = 1'b1} cfg_st_e;

  cfg_st_e                          cst_q;
  logic [8:0][COEF_DW-1:0]          coef_q;
  logic [2:0][OFS_DW-1:0]           ofs_q;
  logic [11:0]                      sign_q;
  logic [PIX_DW-1:0]                round_q;
  logic [4:0]                       shift_q;
  logic                             bypass_q;

  logic                             s1_vld_q, s2_vld_q, out_vld_q;
  logic [8:0][PROD_W-1:0]           s1_prod_q, prod_d;
  logic [2:0][PIX_DW-1:0]           s1_pix_q, s2_pix_q, s0_pix;
  logic [2:0][SUM_W-1:0]            s2_sum_q, sum_d;
  logic [2:0][PIX_DW-1:0]           pre_q, res_d;

  logic s3_ld, s2_ld, s1_ld, s1_vld_d, copy;

  // A stage can load when it is empty or its content leaves this cycle.
  assign s3_ld    = ~out_vld_q | out_rdy;
  assign s2_ld    = ~s2_vld_q | s3_ld;
  assign s1_ld    = ~s1_vld_q | s2_ld;
  assign in_rdy   = (cst_q == CFG_IDLE) & ~cfg_load & s1_ld;
  assign s1_vld_d = in_vld & in_rdy;
  assign copy     = (cst_q == CFG_PEND) & ~s1_vld_q & ~s2_vld_q & ~out_vld_q;
  assign cfg_ack  = copy;

  assign s0_pix  = {in_xr, in_xb, in_y};
  assign out_vld = out_vld_q;
  assign pre_r   = pre_q[0];
  assign pre_g   = pre_q[1];
  assign pre_b   = pre_q[2];

  for (genvar k = 0; k < 9; k++) begin : g_prod
    assign prod_d[k] = PROD_W'(coef_q[k]) * PROD_W'(s0_pix[k % 3]);
  end

  for (genvar r = 0; r < 3; r++) begin : g_row
    logic [3:0][SUM_W-1:0]   term;
    logic signed [RES_W-1:0] biased;
    logic signed [RES_W-1:0] shifted;

    for (genvar j = 0; j < 3; j++) begin : g_term
      assign term[j] = sign_q[4*r+j] ? SUM_W'(0) - SUM_W'(s1_prod_q[3*r+j])
                                     : SUM_W'(s1_prod_q[3*r+j]);
    end
    assign term[3]  = sign_q[4*r+3] ? SUM_W'(0) - SUM_W'(ofs_q[r]) : SUM_W'(ofs_q[r]);
    assign sum_d[r] = term[0] + term[1] + term[2] + term[3];

    // Widen by one bit so the rounding add cannot wrap the sign.
    assign biased   = RES_W'($signed(s2_sum_q[r])) + RES_W'(round_q);
    assign shifted  = biased >>> shift_q;
    assign res_d[r] = bypass_q                   ? s2_pix_q[r] :
                      shifted[RES_W-1]           ? '0 :
                      (|shifted[RES_W-2:PIX_DW]) ? '1 : shifted[PIX_DW-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cst_q     <= CFG_IDLE;
      coef_q    <= '0;
      ofs_q     <= '0;
      sign_q    <= '0;
      round_q   <= '0;
      shift_q   <= '0;
      bypass_q  <= 1'b0;
      s1_vld_q  <= 1'b0;
      s2_vld_q  <= 1'b0;
      out_vld_q <= 1'b0;
      s1_prod_q <= '0;
      s1_pix_q  <= '0;
      s2_sum_q  <= '0;
      s2_pix_q  <= '0;
      pre_q     <= '0;
    end else begin
      if (s1_ld) begin
        s1_vld_q <= s1_vld_d;
        if (s1_vld_d) begin
          s1_prod_q <= prod_d;
          s1_pix_q  <= s0_pix;
        end
      end
      if (s2_ld) begin
        s2_vld_q <= s1_vld_q;
        if (s1_vld_q) begin
          s2_sum_q <= sum_d;
          s2_pix_q <= s1_pix_q;
        end
      end
      if (s3_ld) begin
        out_vld_q <= s2_vld_q;
        if (s2_vld_q) pre_q <= res_d;
      end
      case (cst_q)
        CFG_IDLE: if (cfg_load) cst_q <= CFG_PEND;
        CFG_PEND: begin
          if (copy) begin
            cst_q    <= CFG_IDLE;
            coef_q   <= cfg_coef;
            ofs_q    <= cfg_ofs;
            sign_q   <= cfg_sign;
            round_q  <= cfg_round;
            shift_q  <= cfg_shift;
            bypass_q <= cfg_bypass;
          end
        end
        default: cst_q <= CFG_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
